// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared Wishbone bus widths, master count and arbiter state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_SEL_W = 2;
    localparam int NUM_M    = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_rr_pick.sv
// ============================================================================
// Module   : wb_rr_pick
// Brief    : Combinational 4-way round-robin picker, search starts at last+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       any,
    output logic [1:0] pick
);

    assign any = |req;

    // Scan farthest-first so the nearest requester after last overwrites.
    always_comb begin
        pick = last;
        for (int i = 4; i >= 1; i--) begin
            if (req[2'(last + 2'(i))]) begin
                pick = 2'(last + 2'(i));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Brief    : Four-master to one-slave Wishbone round-robin arbiter; grant held
//            for a whole cyc tenure. WB_ARBITER_TIMEOUT_EN adds a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] wbm_0_dat_i,
    input  logic [WB_ADR_W-1:0]   wbm_0_adr_i,
    input  logic [WB_SEL_W-1:0]   wbm_0_sel_i,
    input  logic                  wbm_0_we_i,
    input  logic                  wbm_0_cyc_i,
    input  logic                  wbm_0_stb_i,
    output logic [DATA_WIDTH-1:0] wbm_0_dat_o,
    output logic                  wbm_0_ack_o,
    input  logic [DATA_WIDTH-1:0] wbm_1_dat_i,
    input  logic [WB_ADR_W-1:0]   wbm_1_adr_i,
    input  logic [WB_SEL_W-1:0]   wbm_1_sel_i,
    input  logic                  wbm_1_we_i,
    input  logic                  wbm_1_cyc_i,
    input  logic                  wbm_1_stb_i,
    output logic [DATA_WIDTH-1:0] wbm_1_dat_o,
    output logic                  wbm_1_ack_o,
    input  logic [DATA_WIDTH-1:0] wbm_2_dat_i,
    input  logic [WB_ADR_W-1:0]   wbm_2_adr_i,
    input  logic [WB_SEL_W-1:0]   wbm_2_sel_i,
    input  logic                  wbm_2_we_i,
    input  logic                  wbm_2_cyc_i,
    input  logic                  wbm_2_stb_i,
    output logic [DATA_WIDTH-1:0] wbm_2_dat_o,
    output logic                  wbm_2_ack_o,
    input  logic [DATA_WIDTH-1:0] wbm_3_dat_i,
    input  logic [WB_ADR_W-1:0]   wbm_3_adr_i,
    input  logic [WB_SEL_W-1:0]   wbm_3_sel_i,
    input  logic                  wbm_3_we_i,
    input  logic                  wbm_3_cyc_i,
    input  logic                  wbm_3_stb_i,
    output logic [DATA_WIDTH-1:0] wbm_3_dat_o,
    output logic                  wbm_3_ack_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic [WB_ADR_W-1:0]   wbs_adr_o,
    output logic [WB_SEL_W-1:0]   wbs_sel_o,
    output logic                  wbs_we_o,
    output logic                  wbs_cyc_o,
    output logic                  wbs_stb_o,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    input  logic                  wbs_ack_i
);

    logic [DATA_WIDTH-1:0] w_m_dat  [NUM_M];
    logic [WB_ADR_W-1:0]   w_m_adr  [NUM_M];
    logic [WB_SEL_W-1:0]   w_m_sel  [NUM_M];
    logic [DATA_WIDTH-1:0] w_rdat   [NUM_M];
    logic [NUM_M-1:0]      w_m_we;
    logic [NUM_M-1:0]      w_m_cyc;
    logic [NUM_M-1:0]      w_m_stb;
    logic [NUM_M-1:0]      w_ack;

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [1:0] r_gnt;
    logic [1:0] r_last;
    logic [1:0] w_pick;
    logic       w_any;
    logic       w_g_cyc;
    logic       w_g_stb;
    logic       w_timeout;

    assign w_m_dat[0] = wbm_0_dat_i;
    assign w_m_dat[1] = wbm_1_dat_i;
    assign w_m_dat[2] = wbm_2_dat_i;
    assign w_m_dat[3] = wbm_3_dat_i;
    assign w_m_adr[0] = wbm_0_adr_i;
    assign w_m_adr[1] = wbm_1_adr_i;
    assign w_m_adr[2] = wbm_2_adr_i;
    assign w_m_adr[3] = wbm_3_adr_i;
    assign w_m_sel[0] = wbm_0_sel_i;
    assign w_m_sel[1] = wbm_1_sel_i;
    assign w_m_sel[2] = wbm_2_sel_i;
    assign w_m_sel[3] = wbm_3_sel_i;
    assign w_m_we     = {wbm_3_we_i,  wbm_2_we_i,  wbm_1_we_i,  wbm_0_we_i};
    assign w_m_cyc    = {wbm_3_cyc_i, wbm_2_cyc_i, wbm_1_cyc_i, wbm_0_cyc_i};
    assign w_m_stb    = {wbm_3_stb_i, wbm_2_stb_i, wbm_1_stb_i, wbm_0_stb_i};

    assign w_g_cyc = w_m_cyc[r_gnt];
    assign w_g_stb = w_m_stb[r_gnt];

    wb_rr_pick u_pick (
        .req  (w_m_cyc),
        .last (r_last),
        .any  (w_any),
        .pick (w_pick)
    );

`ifdef WB_ARBITER_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       w_stall;

    assign w_stall   = (r_state == GRANT) && w_g_cyc && w_g_stb && !wbs_ack_i;
    // Fires on the stalled cycle that would bring the count up to the limit.
    assign w_timeout = w_stall && (r_wdog == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wdog <= 8'd0;
        end else if ((r_state != GRANT) || wbs_ack_i || w_timeout) begin
            r_wdog <= 8'd0;
        end else if (w_stall) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end
`else
    logic [7:0] w_unused_timeout;

    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE) begin
            if (w_any) begin
                w_state_nxt = GRANT;
            end
        end else if (!w_g_cyc || w_timeout) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_gnt   <= 2'd0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_any) begin
                r_gnt  <= w_pick;
                r_last <= w_pick;
            end
        end
    end

    always_comb begin
        wbs_dat_o = '0;
        wbs_adr_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        if (r_state == GRANT) begin
            wbs_dat_o = w_m_dat[r_gnt];
            wbs_adr_o = w_m_adr[r_gnt];
            wbs_sel_o = w_m_sel[r_gnt];
            wbs_we_o  = w_m_we[r_gnt];
            wbs_cyc_o = w_g_cyc && !w_timeout;
            wbs_stb_o = w_g_cyc && w_g_stb && !w_timeout;
        end
    end

    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_ack
        assign w_ack[gi]  = (r_state == GRANT) && (r_gnt == 2'(gi)) && w_m_cyc[gi]
                            && (wbs_ack_i || w_timeout);
        assign w_rdat[gi] = (w_timeout && (r_gnt == 2'(gi))) ? '1 : wbs_dat_i;
    end

    assign wbm_0_ack_o = w_ack[0];
    assign wbm_1_ack_o = w_ack[1];
    assign wbm_2_ack_o = w_ack[2];
    assign wbm_3_ack_o = w_ack[3];
    assign wbm_0_dat_o = w_rdat[0];
    assign wbm_1_dat_o = w_rdat[1];
    assign wbm_2_dat_o = w_rdat[2];
    assign wbm_3_dat_o = w_rdat[3];

endmodule

`default_nettype wire
